alu_unit: RTL and testbench



---
 rtl/alu_unit.sv | 96 +++++++++
 tb/tb_alu_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Registered ADD/SUB unit for the accumulator datapath: one-cycle latency,
// with zero/negative/carry/overflow status flags and a valid pipeline.
module alu_unit #(
    parameter int E_BITS = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [E_BITS-1:0] op_1,
    input  logic [E_BITS-1:0] op_2,
    input  logic              i_op,
    input  logic              i_valid,
    output logic [E_BITS-1:0] o_res,
    output logic              o_valid,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_carry,
    output logic              o_ovf
);

    localparam int MSB = E_BITS - 1;

    // Signed overflow: both addends share a sign and the result does not.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    logic [E_BITS-1:0] opb_s;
    logic [E_BITS:0]   sum_s;
    logic              ovf_s;

    logic [E_BITS-1:0] res_q,   res_d;
    logic              valid_q, valid_d;
    logic              zero_q,  zero_d;
    logic              neg_q,   neg_d;
    logic              carry_q, carry_d;
    logic              ovf_q,   ovf_d;

    // Datapath: SUB folds into ADD via inverted op_2 and carry-in of one.
    always_comb begin
        opb_s = op_2;
        if (i_op) begin
            opb_s = ~op_2;
        end else begin
            opb_s = op_2;
        end
        sum_s = {1'b0, op_1} + {1'b0, opb_s} + {{E_BITS{1'b0}}, i_op};
        ovf_s = ovf_f(op_1[MSB], opb_s[MSB], sum_s[MSB]);
    end

    // Next-state selection: capture on valid, otherwise hold result and flags.
    always_comb begin
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (i_valid) begin
            res_d   = sum_s[MSB:0];
            zero_d  = (sum_s[MSB:0] == {E_BITS{1'b0}});
            neg_d   = sum_s[MSB];
            carry_d = sum_s[E_BITS];
            ovf_d   = ovf_s;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q   <= {E_BITS{1'b0}};
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_res   = res_q;
    assign o_valid = valid_q;
    assign o_zero  = zero_q;
    assign o_neg   = neg_q;
    assign o_carry = carry_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed and random bench for alu_unit with a scoreboard queue of
// expected results, compared one cycle after each valid input.
module tb_alu_unit;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] op_1;
    logic [W-1:0] op_2;
    logic         op;
    logic         valid;
    logic [W-1:0] res;
    logic         o_valid, o_zero, o_neg, o_carry, o_ovf;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         neg;
        logic         carry;
        logic         ovf;
    } exp_t;

    exp_t scb[$];
    exp_t last_e;
    int   errors;
    int   checks;

    alu_unit #(.E_BITS(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .op_1    (op_1),
        .op_2    (op_2),
        .i_op    (op),
        .i_valid (valid),
        .o_res   (res),
        .o_valid (o_valid),
        .o_zero  (o_zero),
        .o_neg   (o_neg),
        .o_carry (o_carry),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model using integer arithmetic on the signed/unsigned values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t        e;
        int          sa, sb, sr;
        logic [W:0]  wide;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            sr      = sa - sb;
            e.res   = a - b;
            e.carry = (a >= b);
        end else begin
            sr      = sa + sb;
            wide    = {1'b0, a} + {1'b0, b};
            e.res   = a + b;
            e.carry = wide[W];
        end
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.zero = (e.res == 16'h0000);
        e.neg  = e.res[W-1];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e, input logic v);
        check({tag, ".res"},   {16'h0000, res}, {16'h0000, e.res});
        check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
        check({tag, ".zero"},  {31'd0, o_zero},  {31'd0, e.zero});
        check({tag, ".neg"},   {31'd0, o_neg},   {31'd0, e.neg});
        check({tag, ".carry"}, {31'd0, o_carry}, {31'd0, e.carry});
        check({tag, ".ovf"},   {31'd0, o_ovf},   {31'd0, e.ovf});
    endtask

    // Drive one valid op at the falling edge, compare just after the next rising edge.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        @(negedge clk);
        op_1  = a;
        op_2  = b;
        op    = sub;
        valid = 1'b1;
        scb.push_back(model(a, b, sub));
        @(posedge clk);
        #1;
        if (scb.size() == 0) begin
            check({tag, ".scb_empty"}, 32'd1, 32'd0);
        end else begin
            e = scb.pop_front();
            last_e = e;
            check_all(tag, e, 1'b1);
        end
    endtask

    initial begin
        exp_t rst_e;
        errors = 0;
        checks = 0;
        rst_e.res = 16'h0000; rst_e.zero = 1'b1; rst_e.neg = 1'b0;
        rst_e.carry = 1'b0;   rst_e.ovf = 1'b0;
        rst_n = 1'b0;
        op_1 = 16'h1234; op_2 = 16'h4321; op = 1'b0; valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", rst_e, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;

        do_op("add7_2",  16'd7,    16'd2,    1'b0);
        do_op("sub7_2",  16'd7,    16'd2,    1'b1);
        do_op("sub2_7",  16'd2,    16'd7,    1'b1);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
        do_op("add_wrap",16'hFFFF, 16'h0001, 1'b0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
        do_op("sub_zero",16'h1234, 16'h1234, 1'b1);
        do_op("sub_min", 16'h0000, 16'h8000, 1'b1);

        // Hold: three idle cycles with operands toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = 1'b0;
            op_1  = 16'(16'hA5A5 ^ i);
            op_2  = 16'(16'h5A5A + i);
            op    = op ^ 1'b1;
            #2;
            op_1  = ~op_1;
            @(posedge clk);
            #1;
            check_all("hold", last_e, 1'b0);
        end

        do_op("b2b_add", 16'd100,  16'd23,   1'b0);
        do_op("b2b_sub", 16'd100,  16'd23,   1'b1);

        for (int i = 0; i < 20; i++) begin
            do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Asynchronous reset mid-cycle, no clock edge in between
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", rst_e, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_hold", rst_e, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        do_op("post_rst", 16'h0003, 16'h0005, 1'b1);

        @(negedge clk);
        valid = 1'b0;
        check("scb_drained", scb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
